// File: rtl/perceptron_if.sv
// Strobe/ready links between the perceptron and its argument/error producers and consumers.
// Groups the argument, result, error and feedback channels; no logic.
// Each channel transfers on a cycle where stb && rdy.
interface perceptron_if #(
    parameter int N  = 2,
    parameter int AW = 8,
    parameter int WW = 16
);
    logic            arg_stb;
    logic [N*AW-1:0] arg_dat;
    logic            arg_rdy;
    logic            res_stb;
    logic [WW-1:0]   res_dat;
    logic            res_rdy;
    logic            err_stb;
    logic [WW-1:0]   err_dat;
    logic            err_rdy;
    logic            fbk_stb;
    logic [N*WW-1:0] fbk_dat;
    logic            fbk_rdy;

    // Producer/consumer side (drives arguments and errors, accepts results and feedback)
    modport master (
        output arg_stb, arg_dat, res_rdy, err_stb, err_dat, fbk_rdy,
        input  arg_rdy, res_stb, res_dat, err_rdy, fbk_stb, fbk_dat
    );

    // Perceptron side
    modport slave (
        input  arg_stb, arg_dat, res_rdy, err_stb, err_dat, fbk_rdy,
        output arg_rdy, res_stb, res_dat, err_rdy, fbk_stb, fbk_dat
    );
endinterface

// File: rtl/perceptron.sv
// Single trainable neuron: saturating fixed-point dot product of N unsigned args with N signed weights plus bias.
// Result valid N+1 cycles after the argument handshake; training adds N cycles of feedback and N of update.
// Every strobe holds with stable data until its rdy; arg_rdy/err_rdy are low outside their accepting states.
module perceptron #(
    parameter int N    = 2,
    parameter int AW   = 8,
    parameter int WW   = 16,
    parameter int FRAC = 8,
    parameter int RW   = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [RW-1:0] rate,
    perceptron_if.slave   bus,
    output logic          sat,
    input  logic          sat_clr
);
    // Intermediate wide enough for acc + weight*arg; widened further when weight*delta needs it,
    // so every product is exact before it is shifted and clamped.
    localparam int IW   = WW + AW + 2;
    localparam int XW   = (2 * WW > IW) ? 2 * WW : IW;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);
    localparam logic signed [XW-1:0] SMAX = {{(XW-WW+1){1'b0}}, {(WW-1){1'b1}}};
    localparam logic signed [XW-1:0] SMIN = {{(XW-WW+1){1'b1}}, {(WW-1){1'b0}}};

    typedef enum logic [2:0] {ST_ARG, ST_MAC, ST_RES, ST_DEL, ST_ERR, ST_FBK, ST_UPD} state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [WW-1:0]   w_q   [N];
    logic [WW-1:0]   w_d   [N];
    logic [AW-1:0]   arg_q [N];
    logic [AW-1:0]   arg_d [N];
    logic [WW-1:0]   fbk_q [N];
    logic [WW-1:0]   fbk_d [N];
    logic [WW-1:0]   bias_q, bias_d;
    logic [WW-1:0]   acc_q, acc_d;
    logic [WW-1:0]   delta_q, delta_d;
    logic [RW-1:0]   rate_q, rate_d;
    logic            res_stb_q, res_stb_d;
    logic            fbk_stb_q, fbk_stb_d;
    logic            arg_rdy_q, arg_rdy_d;
    logic            err_rdy_q, err_rdy_d;
    logic            sat_q, sat_d;

    logic signed [XW-1:0] prod, sum, step_x, bsum;
    logic [WW-1:0]        step, dsh;
    logic                 h_a, h_b, h_c, sat_hit;

    function automatic logic signed [XW-1:0] sxw(input logic [WW-1:0] v);
        return {{(XW-WW){v[WW-1]}}, v};
    endfunction

    function automatic logic signed [XW-1:0] zxa(input logic [AW-1:0] v);
        return {{(XW-AW){1'b0}}, v};
    endfunction

    // Clamp to the signed WW range; hit reports that the clamp actually limited the value.
    function automatic logic [WW-1:0] clamp(input logic signed [XW-1:0] v, output logic hit);
        hit = 1'b0;
        clamp = v[WW-1:0];
        if (v > SMAX) begin
            clamp = SMAX[WW-1:0];
            hit   = 1'b1;
        end else if (v < SMIN) begin
            clamp = SMIN[WW-1:0];
            hit   = 1'b1;
        end
    endfunction

    // Next-state, datapath and registered-output computation for all states
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        bias_d    = bias_q;
        acc_d     = acc_q;
        delta_d   = delta_q;
        rate_d    = rate_q;
        res_stb_d = res_stb_q;
        fbk_stb_d = fbk_stb_q;
        arg_rdy_d = arg_rdy_q;
        err_rdy_d = err_rdy_q;
        prod      = '0;
        sum       = '0;
        step_x    = '0;
        bsum      = '0;
        step      = '0;
        dsh       = '0;
        h_a       = 1'b0;
        h_b       = 1'b0;
        h_c       = 1'b0;
        sat_hit   = 1'b0;
        for (int i = 0; i < N; i++) begin
            w_d[i]   = w_q[i];
            arg_d[i] = arg_q[i];
            fbk_d[i] = fbk_q[i];
        end

        case (state_q)
            ST_ARG: begin
                if (arg_rdy_q && bus.arg_stb) begin
                    for (int i = 0; i < N; i++) arg_d[i] = bus.arg_dat[i*AW +: AW];
                    acc_d     = bias_q;
                    idx_d     = '0;
                    arg_rdy_d = 1'b0;
                    state_d   = ST_MAC;
                end
            end
            ST_MAC: begin
                prod    = sxw(w_q[idx_q]) * zxa(arg_q[idx_q]);
                sum     = sxw(acc_q) + (prod >>> FRAC);
                acc_d   = clamp(sum, h_a);
                sat_hit = h_a;
                if (idx_q == LAST) begin
                    idx_d     = '0;
                    res_stb_d = 1'b1;
                    state_d   = ST_RES;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            ST_RES: begin
                if (res_stb_q && bus.res_rdy) begin
                    res_stb_d = 1'b0;
                    if (en) begin
                        err_rdy_d = 1'b1;
                        state_d   = ST_DEL;
                    end else begin
                        arg_rdy_d = 1'b1;
                        state_d   = ST_ARG;
                    end
                end
            end
            ST_DEL: begin
                if (err_rdy_q && bus.err_stb) begin
                    delta_d   = bus.err_dat;
                    rate_d    = rate;
                    err_rdy_d = 1'b0;
                    idx_d     = '0;
                    state_d   = ST_ERR;
                end
            end
            ST_ERR: begin
                // Feedback uses the weights as they were for the forward pass
                prod          = sxw(w_q[idx_q]) * sxw(delta_q);
                fbk_d[idx_q]  = clamp(prod >>> FRAC, h_a);
                sat_hit       = h_a;
                if (idx_q == LAST) begin
                    idx_d     = '0;
                    fbk_stb_d = 1'b1;
                    state_d   = ST_FBK;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            ST_FBK: begin
                if (fbk_stb_q && bus.fbk_rdy) begin
                    fbk_stb_d = 1'b0;
                    idx_d     = '0;
                    state_d   = ST_UPD;
                end
            end
            ST_UPD: begin
                prod         = sxw(delta_q) * zxa(arg_q[idx_q]);
                step_x       = (prod >>> FRAC) >>> rate_q;
                step         = clamp(step_x, h_a);
                sum          = sxw(w_q[idx_q]) + sxw(step);
                w_d[idx_q]   = clamp(sum, h_b);
                if (idx_q == '0) begin
                    dsh    = $signed(delta_q) >>> rate_q;
                    bsum   = sxw(bias_q) + sxw(dsh);
                    bias_d = clamp(bsum, h_c);
                end
                sat_hit = h_a | h_b | h_c;
                if (idx_q == LAST) begin
                    idx_d     = '0;
                    arg_rdy_d = 1'b1;
                    state_d   = ST_ARG;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            default: begin
                arg_rdy_d = 1'b1;
                res_stb_d = 1'b0;
                fbk_stb_d = 1'b0;
                err_rdy_d = 1'b0;
                state_d   = ST_ARG;
            end
        endcase

        // A saturation in the same cycle as a clear wins
        sat_d = (sat_q && !sat_clr) || sat_hit;
    end

    // State register with synchronous reset; reset discards any in-flight transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_ARG;
            idx_q     <= '0;
            bias_q    <= '0;
            acc_q     <= '0;
            delta_q   <= '0;
            rate_q    <= '0;
            res_stb_q <= 1'b0;
            fbk_stb_q <= 1'b0;
            arg_rdy_q <= 1'b1;
            err_rdy_q <= 1'b0;
            sat_q     <= 1'b0;
            for (int i = 0; i < N; i++) begin
                w_q[i]   <= '0;
                arg_q[i] <= '0;
                fbk_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            bias_q    <= bias_d;
            acc_q     <= acc_d;
            delta_q   <= delta_d;
            rate_q    <= rate_d;
            res_stb_q <= res_stb_d;
            fbk_stb_q <= fbk_stb_d;
            arg_rdy_q <= arg_rdy_d;
            err_rdy_q <= err_rdy_d;
            sat_q     <= sat_d;
            for (int i = 0; i < N; i++) begin
                w_q[i]   <= w_d[i];
                arg_q[i] <= arg_d[i];
                fbk_q[i] <= fbk_d[i];
            end
        end
    end

    assign bus.arg_rdy = arg_rdy_q;
    assign bus.res_stb = res_stb_q;
    assign bus.res_dat = acc_q;
    assign bus.err_rdy = err_rdy_q;
    assign bus.fbk_stb = fbk_stb_q;
    assign sat         = sat_q;

    for (genvar g = 0; g < N; g++) begin : g_fbk
        assign bus.fbk_dat[g*WW +: WW] = fbk_q[g];
    end
endmodule
